shift_add_multiplier: RTL and testbench

- Sequential N×N unsigned multiplier built around the team's N-bit ripple_adder; it is both the adder's upstream driver and its downstream consumer.
- The block drives the adder operands (a0, a1, ci) and registers the adder results (sum, co) once per cycle. It retires one multiplier bit per clock.
- It sits between an operand source using a start pulse and a result consumer using a done pulse.
- The ripple_adder is instantiated outside this block. All connections go through the add_* ports.

---
 rtl/shift_add_multiplier.sv | 134 +++++++++++++
 tb/tb_shift_add_multiplier.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential NxN unsigned shift-add multiplier driving an external N-bit ripple adder.
// Latency: start accepted at edge E, N RUN edges, done high in the cycle after edge E+N; II = N+2.
// Backpressure: none; start is sampled only in IDLE, and start while busy is dropped (never queued).
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   start              request, sampled only in IDLE
//   mcand, mplier      N-bit operands, captured on the accepting edge
//   add_a0/a1/ci       operands to the external adder (a0 = upper P, a1 = gated mcand, ci = 0)
//   add_sum, add_co    result from the external adder, consumed on every RUN edge
//   busy               high in RUN and DONE
//   done               one-cycle pulse, product valid
//   product            2N-bit result, held until the next completion
module shift_add_multiplier #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic [N-1:0]   add_a0,
  output logic [N-1:0]   add_a1,
  output logic           add_ci,
  input  logic [N-1:0]   add_sum,
  input  logic           add_co,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  // Step counter only has to reach N-1, so ceil(log2(N)) bits suffice (min 1).
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2*N-1:0]   r_p;        // {accumulated high half, remaining multiplier bits}
  logic [N-1:0]     r_mcand;
  logic [CW-1:0]    r_cnt;
  logic [2*N-1:0]   r_product;

  logic             w_accept;
  logic             w_last;
  logic [2*N-1:0]   w_p_step;

  // ---------------------------------------------------------------------------
  // Adder drive. Defined in every state; outside RUN the adder result is
  // simply not consumed, so no gating on state is needed here.
  // ---------------------------------------------------------------------------
  assign add_a0 = r_p[2*N-1:N];
  assign add_a1 = r_p[0] ? r_mcand : '0;
  assign add_ci = 1'b0;

  // One shift-add step: the carry lands in the MSB, so the full N+1 bit
  // adder result never overflows the 2N-bit register.
  assign w_p_step = {add_co, add_sum, r_p[N-1:1]};

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p       <= '0;
      r_mcand   <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      if (w_accept) begin
        r_mcand <= mcand;
        r_p     <= {{N{1'b0}}, mplier};
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_p   <= w_p_step;
        // Stops at N-1 because the FSM leaves RUN on that same edge.
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_product <= w_p_step;
        end
      end
    end
  end

  // Pure decode of the registered state: no combinational input-to-output path.
  assign busy    = (r_state == S_RUN) || (r_state == S_DONE);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier at N=4 (directed cases) and N=8 (random sweep).
// The external ripple adder is modelled here as a plain N-bit add with carry out.
// Expected results come from integer multiplication and the multiplier's bit pattern.
module tb_shift_add_multiplier;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N=4 instance
  logic       start4;
  logic [3:0] mc4, mp4, a0_4, a1_4, sum4;
  logic       ci4, co4, busy4, done4;
  logic [7:0] prod4;

  // N=8 instance
  logic       start8;
  logic [7:0] mc8, mp8, a0_8, a1_8, sum8;
  logic       ci8, co8, busy8, done8;
  logic [15:0] prod8;

  assign {co4, sum4} = 5'(a0_4) + 5'(a1_4) + 5'(ci4);
  assign {co8, sum8} = 9'(a0_8) + 9'(a1_8) + 9'(ci8);

  shift_add_multiplier #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .mcand(mc4), .mplier(mp4),
    .add_a0(a0_4), .add_a1(a1_4), .add_ci(ci4), .add_sum(sum4), .add_co(co4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  shift_add_multiplier #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .mcand(mc8), .mplier(mp8),
    .add_a0(a0_8), .add_a1(a1_8), .add_ci(ci8), .add_sum(sum8), .add_co(co8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  int n_vec = 0;
  int n_err = 0;
  int last_co_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic f_busy(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction
  function automatic logic f_done(input int w);
    return (w == 4) ? done4 : done8;
  endfunction
  function automatic logic f_co(input int w);
    return (w == 4) ? co4 : co8;
  endfunction
  function automatic logic f_ci(input int w);
    return (w == 4) ? ci4 : ci8;
  endfunction
  function automatic logic [7:0] f_a1(input int w);
    return (w == 4) ? {4'h0, a1_4} : a1_8;
  endfunction
  function automatic logic [15:0] f_prod(input int w);
    return (w == 4) ? {8'h00, prod4} : prod8;
  endfunction

  task automatic drive(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
    if (w == 4) begin
      start4 = s; mc4 = a[3:0]; mp4 = b[3:0];
    end else begin
      start8 = s; mc8 = a; mp8 = b;
    end
  endtask

  // One complete operation from an idle DUT. Cycle 1 is the cycle that starts
  // at the accepting edge; done is expected in cycle w+1 and busy in cycles 1..w+1.
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input string tag);
    int lat, busy_n, co_n, ci_bad, a1_bad, idx;
    bit got;
    logic [7:0] a1_seen[$];
    logic [7:0] a1_exp;
    lat = 0; busy_n = 0; co_n = 0; ci_bad = 0; a1_bad = 0; got = 1'b0;
    @(negedge clk);
    drive(w, 1'b1, a, b);
    @(posedge clk);
    #1;
    drive(w, 1'b0, 8'($urandom), 8'($urandom));
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (f_busy(w)) busy_n++;
      if (f_done(w)) begin
        got = 1'b1;
      end else begin
        a1_seen.push_back(f_a1(w));
        if (f_co(w)) co_n++;
        if (f_ci(w)) ci_bad++;
      end
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_done_lat"}, 32'(lat), 32'(w + 1));
    chk({tag, "_product"}, 32'(f_prod(w)), 32'(a) * 32'(b));
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(w + 1));
    chk({tag, "_ci_zero"}, 32'(ci_bad), 32'd0);
    // Each RUN cycle adds mcand exactly when the corresponding multiplier bit is set.
    idx = 0;
    foreach (a1_seen[i]) begin
      a1_exp = b[idx] ? a : 8'h00;
      if (idx < w && a1_seen[i] != a1_exp) a1_bad++;
      idx++;
    end
    chk({tag, "_a1_count"}, 32'(a1_seen.size()), 32'(w));
    chk({tag, "_a1_seq"}, 32'(a1_bad), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {30'd0, f_done(w), f_busy(w)}, 32'd0);
    last_co_cnt = co_n;
  endtask

  initial begin
    int cyc, bad;
    bit got;
    logic [7:0] ra, rb;
    rst = 1'b1;
    drive(4, 1'b0, 8'h00, 8'h00);
    drive(8, 1'b0, 8'h00, 8'h00);
    #12;
    chk("rst_state4", {busy4, done4, 14'd0, prod4, a0_4, a1_4}, 32'd0);
    chk("rst_state8", {busy8, done8, prod8, 14'd0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed N=4 cases
    run_op(4, 8'd13, 8'd11, "m13x11");
    run_op(4, 8'd15, 8'd15, "m15x15");
    chk("m15x15_co_seen", 32'(last_co_cnt > 0), 32'd1);
    run_op(4, 8'd0, 8'd9, "m0x9");
    run_op(4, 8'd9, 8'd0, "m9x0");

    // start held high: 3x5, stray starts/operand changes during RUN/DONE ignored,
    // re-accept on the first IDLE edge with 2x7.
    @(negedge clk);
    drive(4, 1'b1, 8'd3, 8'd5);
    @(posedge clk);
    for (cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      drive(4, 1'b1, 8'($urandom), 8'($urandom));
      chk("held_run_busy", 32'(busy4 & ~done4), 32'd1);
    end
    @(negedge clk);
    chk("held_done_cyc5", 32'(done4), 32'd1);
    chk("held_prod1", 32'(prod4), 32'd15);
    @(negedge clk);
    chk("held_idle_cyc6", 32'(busy4), 32'd0);
    drive(4, 1'b1, 8'd2, 8'd7);
    @(posedge clk);
    #1;
    drive(4, 1'b0, 8'($urandom), 8'($urandom));
    bad = 0; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (done4) got = 1'b1;
      else if (prod4 != 8'd15 || !busy4) bad++;
    end
    chk("held_second_done", 32'(got), 32'd1);
    chk("held_prod_hold", 32'(bad), 32'd0);
    chk("held_prod2", 32'(prod4), 32'd14);

    // Asynchronous reset after two RUN edges aborts the operation.
    @(negedge clk);
    drive(4, 1'b1, 8'd11, 8'd13);
    @(posedge clk);
    #1;
    drive(4, 1'b0, 8'd0, 8'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy4), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async", {23'd0, busy4, done4, prod4}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done4 || busy4) bad++;
    end
    chk("rst_no_done", 32'(bad), 32'd0);
    run_op(4, 8'd7, 8'd6, "m7x6");

    // N=8 sweep: corners plus random operand pairs
    run_op(8, 8'd255, 8'd255, "w8_max");
    run_op(8, 8'd1, 8'd128, "w8_one");
    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(8, ra, rb, "w8_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute bound so a stuck DUT can never hang the run.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
